// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, funct3 encodings,
// mstatus bit positions and the read-modify-write helper.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH= 12'hB82;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [2:0] F3_CSRRW = 3'b001;
  localparam logic [2:0] F3_CSRRS = 3'b010;
  localparam logic [2:0] F3_CSRRC = 3'b011;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old,
                                            input logic [31:0] operand);
    case (op)
      OP_RW:   return operand;
      OP_RS:   return old | operand;
      OP_RC:   return old & ~operand;
      default: return old;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently loadable 32-bit halves.
import csr_pkg::*;

module csr_counter64 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] q
);

  logic [63:0] cnt_r;

  // A half-load takes precedence over the increment in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r <= 64'd0;
    end else if (wr_lo) begin
      cnt_r[31:0] <= wdata;
    end else if (wr_hi) begin
      cnt_r[63:32] <= wdata;
    end else if (inc) begin
      cnt_r <= cnt_r + 64'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign q = cnt_r;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read, read-modify-write commit on the
// next edge, trap entry / mret updates and the cycle/instret counters.
import csr_pkg::*;

module csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        csr_we,
  input  logic [31:0] rs1_data,
  output logic [31:0] csr_rdata,
  output logic        illegal_csr,
  input  logic        instr_retire,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_val,
  input  logic        mret,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  logic [11:0] addr_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rs1_field_s;
  csr_op_e     op_s;
  logic [31:0] operand_s;
  logic [31:0] old_s;
  logic [31:0] new_s;
  logic [31:0] mstatus_s;
  logic        impl_s;
  logic        wants_write_s;
  logic        illegal_s;
  logic        commit_s;
  logic [63:0] mcycle_s;
  logic [63:0] minstret_s;
  logic        unused_s;

  logic        mie_r;
  logic        mpie_r;
  logic [31:0] mie_csr_r;
  logic [29:0] mtvec_r;
  logic [31:0] mscratch_r;
  logic [29:0] mepc_r;
  logic [31:0] mcause_r;
  logic [31:0] mtval_r;

  assign addr_s      = instr[31:20];
  assign funct3_s    = instr[14:12];
  assign rs1_field_s = instr[19:15];
  assign op_s        = csr_op_e'(funct3_s[1:0]);
  assign operand_s   = funct3_s[2] ? {27'd0, rs1_field_s} : rs1_data;
  assign unused_s    = ^{instr[11:0], trap_pc[1:0]};

  always_comb begin
    mstatus_s = 32'h0000_1800;
    mstatus_s[MSTATUS_MIE]  = mie_r;
    mstatus_s[MSTATUS_MPIE] = mpie_r;
  end

  // Address decode and old-value read mux.
  always_comb begin
    impl_s = 1'b1;
    old_s  = 32'h0;
    case (addr_s)
      CSR_MSTATUS:                 old_s = mstatus_s;
      CSR_MIE:                     old_s = mie_csr_r;
      CSR_MTVEC:                   old_s = {mtvec_r, 2'b00};
      CSR_MSCRATCH:                old_s = mscratch_r;
      CSR_MEPC:                    old_s = {mepc_r, 2'b00};
      CSR_MCAUSE:                  old_s = mcause_r;
      CSR_MTVAL:                   old_s = mtval_r;
      CSR_MIP:                     old_s = 32'h0;
      CSR_MCYCLE, CSR_CYCLE:       old_s = mcycle_s[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:     old_s = mcycle_s[63:32];
      CSR_MINSTRET, CSR_INSTRET:   old_s = minstret_s[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: old_s = minstret_s[63:32];
      CSR_MHARTID:                 old_s = HART_ID;
      default:                     impl_s = 1'b0;
    endcase
  end

  // Set/clear with x0 (or zimm 0) is a pure read and never counts as a write.
  always_comb begin
    wants_write_s = 1'b0;
    if (!csr_we || op_s == OP_NONE) begin
      wants_write_s = 1'b0;
    end else if (op_s != OP_RW && rs1_field_s == 5'd0) begin
      wants_write_s = 1'b0;
    end else begin
      wants_write_s = 1'b1;
    end
  end

  assign illegal_s   = csr_we && (!impl_s || (wants_write_s && addr_s[11:10] == 2'b11));
  assign commit_s    = wants_write_s && !illegal_s && !trap_valid && !mret;
  assign new_s       = csr_apply(op_s, old_s, operand_s);
  assign csr_rdata   = illegal_s ? 32'h0 : old_s;
  assign illegal_csr = illegal_s;

  // Architectural state: reset > trap entry > mret > CSR write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mie_r      <= 1'b0;
      mpie_r     <= 1'b0;
      mie_csr_r  <= 32'h0;
      mtvec_r    <= MTVEC_RESET[31:2];
      mscratch_r <= 32'h0;
      mepc_r     <= 30'h0;
      mcause_r   <= 32'h0;
      mtval_r    <= 32'h0;
    end else if (trap_valid) begin
      mepc_r   <= trap_pc[31:2];
      mcause_r <= trap_cause;
      mtval_r  <= trap_val;
      mpie_r   <= mie_r;
      mie_r    <= 1'b0;
    end else if (mret) begin
      mie_r  <= mpie_r;
      mpie_r <= 1'b1;
    end else if (commit_s) begin
      case (addr_s)
        CSR_MSTATUS: begin
          mie_r  <= new_s[MSTATUS_MIE];
          mpie_r <= new_s[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_csr_r  <= new_s;
        CSR_MTVEC:    mtvec_r    <= new_s[31:2];
        CSR_MSCRATCH: mscratch_r <= new_s;
        CSR_MEPC:     mepc_r     <= new_s[31:2];
        CSR_MCAUSE:   mcause_r   <= new_s;
        CSR_MTVAL:    mtval_r    <= new_s;
        default:      mie_r      <= mie_r;
      endcase
    end else begin
      mie_r <= mie_r;
    end
  end

  csr_counter64 u_cycle (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (1'b1),
    .wr_lo   (commit_s && addr_s == CSR_MCYCLE),
    .wr_hi   (commit_s && addr_s == CSR_MCYCLEH),
    .wdata   (new_s),
    .q       (mcycle_s)
  );

  csr_counter64 u_instret (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (instr_retire),
    .wr_lo   (commit_s && addr_s == CSR_MINSTRET),
    .wr_hi   (commit_s && addr_s == CSR_MINSTRETH),
    .wdata   (new_s),
    .q       (minstret_s)
  );

  assign mtvec_o = {mtvec_r, 2'b00};
  assign mepc_o  = {mepc_r, 2'b00};
  assign mie_o   = mie_r;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: a vector table of CSR ops plus hand-written
// trap, mret, counter-carry and mid-run reset sequences, checked via a scoreboard queue.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        csr_we;
  logic [31:0] rs1_data;
  logic [31:0] csr_rdata;
  logic        illegal_csr;
  logic        instr_retire;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_val;
  logic        mret;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        mie_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] addr;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [31:0] data;
    logic        we;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        ill;
    logic        chk_rdata;
  } exp_t;

  vec_t vecs[29];
  exp_t sb[$];

  csr_file #(.MTVEC_RESET(32'h0000_0103), .HART_ID(32'h0000_0005)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr        (instr),
    .csr_we       (csr_we),
    .rs1_data     (rs1_data),
    .csr_rdata    (csr_rdata),
    .illegal_csr  (illegal_csr),
    .instr_retire (instr_retire),
    .trap_valid   (trap_valid),
    .trap_pc      (trap_pc),
    .trap_cause   (trap_cause),
    .trap_val     (trap_val),
    .mret         (mret),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o),
    .mie_o        (mie_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [11:0] a, input logic [2:0] f3, input logic [4:0] r);
    return {a, r, f3, 5'd0, 7'b1110011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One CSR instruction for one cycle; expectation queued at drive, compared mid-cycle.
  task automatic op(input int id, input logic [11:0] a, input logic [2:0] f3, input logic [4:0] r,
                    input logic [31:0] d, input logic we, input logic [31:0] er, input logic ei,
                    input logic chkr);
    exp_t e;
    instr    = mk(a, f3, r);
    rs1_data = d;
    csr_we   = we;
    sb.push_back('{id, er, ei, chkr});
    @(negedge clk);
    e = sb.pop_front();
    if (e.chk_rdata) chk($sformatf("rdata[%0d]", e.id), csr_rdata, e.rdata);
    chk($sformatf("illegal[%0d]", e.id), {31'd0, illegal_csr}, {31'd0, e.ill});
    @(posedge clk);
    #1;
    csr_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // addr, f3, rs1, data, we, exp_rdata, exp_ill
    vecs[0]  = '{12'hB00, 3'b010, 5'd0, 32'h0,         1'b1, 32'd0,         1'b0};
    vecs[1]  = '{12'hB00, 3'b010, 5'd0, 32'h0,         1'b1, 32'd1,         1'b0};
    vecs[2]  = '{12'h300, 3'b010, 5'd0, 32'h0,         1'b1, 32'h0000_1800, 1'b0};
    vecs[3]  = '{12'h340, 3'b001, 5'd5, 32'hDEAD_BEEF, 1'b1, 32'h0,         1'b0};
    vecs[4]  = '{12'h340, 3'b010, 5'd0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[5]  = '{12'h300, 3'b110, 5'd8, 32'h0,         1'b1, 32'h0000_1800, 1'b0};
    vecs[6]  = '{12'h300, 3'b011, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'h0000_1808, 1'b0};
    vecs[7]  = '{12'h300, 3'b010, 5'd0, 32'h0,         1'b1, 32'h0000_1808, 1'b0};
    vecs[8]  = '{12'h340, 3'b111, 5'h0F, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[9]  = '{12'h340, 3'b010, 5'd0, 32'h0,         1'b1, 32'hDEAD_BEE0, 1'b0};
    vecs[10] = '{12'h340, 3'b010, 5'd5, 32'h0000_000F, 1'b1, 32'hDEAD_BEE0, 1'b0};
    vecs[11] = '{12'h7C0, 3'b001, 5'd5, 32'h0000_1234, 1'b1, 32'h0,         1'b1};
    vecs[12] = '{12'hF14, 3'b010, 5'd0, 32'h0,         1'b1, 32'h0000_0005, 1'b0};
    vecs[13] = '{12'h305, 3'b001, 5'd5, 32'h0000_8003, 1'b1, 32'h0000_0100, 1'b0};
    vecs[14] = '{12'h305, 3'b010, 5'd0, 32'h0,         1'b1, 32'h0000_8000, 1'b0};
    vecs[15] = '{12'hC00, 3'b001, 5'd5, 32'h0,         1'b1, 32'h0,         1'b1};
    vecs[16] = '{12'hB00, 3'b010, 5'd0, 32'h0,         1'b1, 32'd16,        1'b0};
    vecs[17] = '{12'hC00, 3'b010, 5'd0, 32'h0,         1'b1, 32'd17,        1'b0};
    vecs[18] = '{12'hC00, 3'b110, 5'd0, 32'h0,         1'b1, 32'd18,        1'b0};
    vecs[19] = '{12'h344, 3'b010, 5'd0, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[20] = '{12'h344, 3'b001, 5'd5, 32'h0000_FFFF, 1'b1, 32'h0,         1'b0};
    vecs[21] = '{12'h344, 3'b010, 5'd0, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[22] = '{12'h341, 3'b001, 5'd5, 32'h0000_2003, 1'b1, 32'h0,         1'b0};
    vecs[23] = '{12'h341, 3'b010, 5'd0, 32'h0,         1'b1, 32'h0000_2000, 1'b0};
    vecs[24] = '{12'hB02, 3'b010, 5'd0, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[25] = '{12'hB80, 3'b010, 5'd0, 32'h0,         1'b1, 32'h0,         1'b0};
    vecs[26] = '{12'h340, 3'b001, 5'd5, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[27] = '{12'h340, 3'b010, 5'd0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[28] = '{12'hF14, 3'b010, 5'd5, 32'h0000_0001, 1'b1, 32'h0,         1'b1};

    reset_n = 1'b0; instr = 32'h0; csr_we = 1'b0; rs1_data = 32'h0;
    instr_retire = 1'b0; trap_valid = 1'b0; trap_pc = 32'h0; trap_cause = 32'h0;
    trap_val = 32'h0; mret = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("reset_mtvec_o", mtvec_o, 32'h0000_0100);
    chk("reset_mepc_o", mepc_o, 32'h0);
    chk("reset_mie_o", {31'd0, mie_o}, 32'd0);

    for (int i = 0; i < 29; i++) begin
      op(i, vecs[i].addr, vecs[i].f3, vecs[i].rs1, vecs[i].data, vecs[i].we,
         vecs[i].exp_rdata, vecs[i].exp_ill, 1'b1);
    end
    chk("table_mie_o", {31'd0, mie_o}, 32'd1);
    chk("table_mtvec_o", mtvec_o, 32'h0000_8000);
    chk("table_mepc_o", mepc_o, 32'h0000_2000);

    // Trap entry with a competing mepc write that must be dropped.
    trap_valid = 1'b1; trap_pc = 32'h0000_1006; trap_cause = 32'd2; trap_val = 32'h13;
    op(100, 12'h341, 3'b001, 5'd5, 32'h0000_5555, 1'b1, 32'h0000_2000, 1'b0, 1'b1);
    trap_valid = 1'b0;
    chk("trap_mepc_o", mepc_o, 32'h0000_1004);
    chk("trap_mie_o", {31'd0, mie_o}, 32'd0);
    op(101, 12'h300, 3'b010, 5'd0, 32'h0, 1'b1, 32'h0000_1880, 1'b0, 1'b1);
    op(102, 12'h342, 3'b010, 5'd0, 32'h0, 1'b1, 32'd2, 1'b0, 1'b1);
    op(103, 12'h343, 3'b010, 5'd0, 32'h0, 1'b1, 32'h13, 1'b0, 1'b1);

    // mret restores MIE; the same-cycle mscratch write is dropped.
    mret = 1'b1;
    op(104, 12'h340, 3'b001, 5'd5, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    mret = 1'b0;
    chk("mret_mie_o", {31'd0, mie_o}, 32'd1);
    op(105, 12'h300, 3'b010, 5'd0, 32'h0, 1'b1, 32'h0000_1888, 1'b0, 1'b1);
    op(106, 12'h340, 3'b010, 5'd0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);

    // instret counting and a load that suppresses the same-cycle increment.
    instr_retire = 1'b1;
    op(110, 12'hB02, 3'b010, 5'd0, 32'h0, 1'b1, 32'd0, 1'b0, 1'b1);
    op(111, 12'hB02, 3'b010, 5'd0, 32'h0, 1'b1, 32'd1, 1'b0, 1'b1);
    op(112, 12'hB02, 3'b010, 5'd0, 32'h0, 1'b1, 32'd2, 1'b0, 1'b1);
    op(113, 12'hB02, 3'b001, 5'd5, 32'd100, 1'b1, 32'd3, 1'b0, 1'b1);
    instr_retire = 1'b0;
    op(114, 12'hB02, 3'b010, 5'd0, 32'h0, 1'b1, 32'd100, 1'b0, 1'b1);
    op(115, 12'hB82, 3'b010, 5'd0, 32'h0, 1'b1, 32'd0, 1'b0, 1'b1);
    op(116, 12'hC02, 3'b010, 5'd0, 32'h0, 1'b1, 32'd100, 1'b0, 1'b1);

    // mcycle carry from the low into the high half.
    op(120, 12'hB00, 3'b001, 5'd5, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0, 1'b0);
    op(121, 12'hB80, 3'b001, 5'd5, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    op(122, 12'hB00, 3'b010, 5'd0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    op(123, 12'hB80, 3'b010, 5'd0, 32'h0, 1'b1, 32'd1, 1'b0, 1'b1);
    op(124, 12'hB00, 3'b010, 5'd0, 32'h0, 1'b1, 32'd1, 1'b0, 1'b1);
    op(125, 12'hC80, 3'b010, 5'd0, 32'h0, 1'b1, 32'd1, 1'b0, 1'b1);

    // Reset mid-run overrides a trap, a write and a retire in the same cycle.
    reset_n = 1'b0; trap_valid = 1'b1; trap_pc = 32'h0000_4444; instr_retire = 1'b1;
    instr = mk(12'h340, 3'b001, 5'd5); rs1_data = 32'h77; csr_we = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1; trap_valid = 1'b0; instr_retire = 1'b0; csr_we = 1'b0;
    chk("rst2_mtvec_o", mtvec_o, 32'h0000_0100);
    chk("rst2_mepc_o", mepc_o, 32'h0);
    chk("rst2_mie_o", {31'd0, mie_o}, 32'd0);
    op(130, 12'hB00, 3'b010, 5'd0, 32'h0, 1'b1, 32'd0, 1'b0, 1'b1);
    op(131, 12'hB00, 3'b010, 5'd0, 32'h0, 1'b1, 32'd1, 1'b0, 1'b1);
    op(132, 12'h340, 3'b010, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    op(133, 12'h300, 3'b010, 5'd0, 32'h0, 1'b1, 32'h0000_1800, 1'b0, 1'b1);
    op(134, 12'hB02, 3'b010, 5'd0, 32'h0, 1'b1, 32'd0, 1'b0, 1'b1);
    op(135, 12'h342, 3'b010, 5'd0, 32'h0, 1'b1, 32'd0, 1'b0, 1'b1);
    op(136, 12'hB80, 3'b010, 5'd0, 32'h0, 1'b1, 32'd0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
